// File: rtl/mem_arbiter.sv
// Shares one memory port between the IFU and LSU. Ties go round-robin, and only one
// transaction is outstanding at a time. A timeout turns a hung access into an error response.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_resp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state;
  logic              owner_lsu;
  logic              last_lsu;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              cnt_hit;
  logic              grant_ifu;
  logic              grant_lsu;
  logic              done_ok;
  logic              done_to;
  logic [DATA_W-1:0] done_data;

  // Round-robin: on a tie, the requester that did not win last time goes first.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == IDLE) begin
      if (ifu_req_valid && lsu_req_valid) begin
        grant_ifu = last_lsu;
        grant_lsu = !last_lsu;
      end else begin
        grant_ifu = ifu_req_valid;
        grant_lsu = lsu_req_valid;
      end
    end
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;

  // The counter saturates at TIMEOUT. It hits TIMEOUT on the edge that ends the timed-out cycle.
  assign cnt_inc   = (cnt == CNT_W'(TIMEOUT)) ? cnt : cnt + CNT_W'(1);
  assign cnt_hit   = (cnt_inc == CNT_W'(TIMEOUT));
  assign done_ok   = (state == WAIT) && mem_resp_valid;
  assign done_to   = ((state == REQ) || (state == WAIT)) && cnt_hit && !done_ok;
  assign done_data = (done_ok && !mem_wen) ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      owner_lsu      <= 1'b0;
      last_lsu       <= 1'b1;
      cnt            <= '0;
      ifu_resp_valid <= 1'b0;
      ifu_rdata      <= '0;
      ifu_resp_err   <= 1'b0;
      lsu_resp_valid <= 1'b0;
      lsu_rdata      <= '0;
      lsu_resp_err   <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_addr       <= '0;
      mem_wen        <= 1'b0;
      mem_wdata      <= '0;
      mem_wmask      <= '0;
    end else begin
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      if (state != IDLE) cnt <= cnt_inc;
      if (done_ok || done_to) begin
        if (owner_lsu) begin
          lsu_resp_valid <= 1'b1;
          lsu_resp_err   <= done_to;
          lsu_rdata      <= done_data;
        end else begin
          ifu_resp_valid <= 1'b1;
          ifu_resp_err   <= done_to;
          ifu_rdata      <= done_data;
        end
        mem_req_valid <= 1'b0;
        state         <= IDLE;
      end else begin
        case (state)
          IDLE: if (grant_ifu || grant_lsu) begin
            owner_lsu     <= grant_lsu;
            last_lsu      <= grant_lsu;
            mem_addr      <= grant_lsu ? lsu_addr : ifu_addr;
            mem_wen       <= grant_lsu && lsu_wen;
            mem_wdata     <= grant_lsu ? lsu_wdata : '0;
            mem_wmask     <= grant_lsu ? lsu_wmask : '0;
            mem_req_valid <= 1'b1;
            cnt           <= '0;
            state         <= REQ;
          end
          REQ: if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter that shares the core's single memory port between the instruction fetch unit (IFU) and the load/store unit (LSU) once the core moves from single-cycle to multicycle operation. It accepts one request at a time with valid/ready handshakes and applies round-robin priority when both units request together. It forwards the winning request to the memory port, waits for the response, and returns it to the granted requester. A timeout counter converts a hung memory access into an error response, so the core cannot deadlock.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum cycles from acceptance to memory response before an error is returned (must be ≥ 2)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  IFU fetch address
- ifu_resp_valid  out  1  one-cycle IFU response pulse
- ifu_rdata  out  DATA_W  fetched word
- ifu_resp_err  out  1  IFU response is a timeout
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  LSU address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  byte write mask
- lsu_resp_valid  out  1  one-cycle LSU response pulse (for loads and stores)
- lsu_rdata  out  DATA_W  load data (0 for stores)
- lsu_resp_err  out  1  LSU response is a timeout
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W/1/DATA_W/DATA_W/8  latched request fields
- mem_resp_valid  in  1  memory response
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - REQ: mem_req_valid is high; waiting for mem_req_ready.
  - WAIT: waiting for mem_resp_valid.
- IDLE grant rules:
  - Only IFU valid → IFU is granted.
  - Only LSU valid → LSU is granted.
  - Both valid → the requester that was not granted last wins.
  - last_grant resets to LSU, so IFU wins the first tie.
- Acceptance:
  - The granted requester's `*_req_ready` is high in IDLE, combinational on its valid. The other requester's ready is 0.
  - At the handshake, the arbiter latches owner, addr, wen, wdata and wmask, updates last_grant, and moves to REQ.
  - For an IFU request, wen, wdata and wmask are latched as 0.
- REQ: mem_req_valid = 1 with the latched fields, held stable until mem_req_ready, then WAIT.
- WAIT: on mem_resp_valid, capture mem_rdata and pulse the owner's resp_valid with err = 0 for one cycle, then IDLE.
  - For a store, lsu_rdata = 0.
- mem_resp_valid outside WAIT is ignored. This includes the cycle mem_req_ready is sampled.
- `*_req_ready` is 0 in REQ and WAIT. At most one transaction is outstanding.
- Timeout:
  - A counter clears at acceptance and increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT without completion: pulse the owner's resp_valid with err = 1 and rdata = 0, drop mem_req_valid, go to IDLE.
  - A late mem_resp_valid after a timeout is ignored.
  - Width is clog2(TIMEOUT+1); the counter saturates and never wraps.
- `*_rdata` and `*_resp_err` are registered. They hold their value until the next response to the same port.

## Timing
- Reset values:
  - State IDLE, last_grant = LSU, counter 0.
  - All `*_resp_valid`, `*_resp_err`, `*_rdata` and mem_req_valid are 0; all mem_* fields are 0.
- Reset mid-transaction: the transaction is dropped with no response pulse. The arbiter is in IDLE in the cycle after reset deasserts.
- Cycle-by-cycle:
  - Cycle 0: handshake in IDLE.
  - Cycle 1: mem_req_valid is high.
  - If mem_req_ready is high in cycle 1, the FSM is in WAIT in cycle 2.
  - mem_resp_valid in cycle N (in WAIT) → resp_valid in cycle N+1, with the FSM in IDLE in cycle N+1.
  - A new request can be accepted in that same cycle N+1.
- Minimum round trip: request at cycle 0, response at cycle 3, given zero-wait memory that drives ready in cycle 1 and resp in cycle 2.
- Timeout: acceptance at cycle 0 → resp_valid with err = 1 at cycle TIMEOUT+1.
- Back-to-back requesters under continuous contention alternate IFU, LSU, IFU, …
- No backpressure on responses: requesters must consume a response pulse in the cycle it is presented.

## Test plan
- Single IFU fetch, addr 0x80000000, zero-wait memory returns 0x00100073 → ifu_resp_valid at cycle 3 with ifu_rdata = 0x00100073, err = 0, lsu_resp_valid stays 0.
- LSU store, addr 0x80000010, wdata 0xDEADBEEF, wmask 0x1; memory holds mem_req_ready low for 4 cycles → mem fields stable throughout, lsu_resp_valid once, lsu_rdata = 0.
- IFU and LSU both valid every cycle for 6 transactions after reset → grant order IFU, LSU, IFU, LSU, IFU, LSU; never both ready in the same cycle.
- TIMEOUT = 8, memory never responds to an LSU load → lsu_resp_valid with err = 1 and rdata = 0 at cycle 9; a stray mem_resp_valid at cycle 12 produces no pulse.
- Reset asserted while in WAIT with an IFU request in flight → no ifu_resp_valid, all outputs 0, and an LSU request accepted in the first cycle after reset completes normally.
